// File: rtl/imem_loader.sv
// Boot-time loader: byte stream (header N, then 4*N big-endian bytes) into the instruction memory write port.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset; no bytes accepted, processor held in reset
// HEADER | waiting for the word-count byte N
// DATA   | assembling words; writes one word per 4th byte
// COMMIT | one cycle so the last memory write lands before release
// CHECK  | (checksum builds only) waiting for the XOR checksum byte
// DONE   | image loaded, processor released
// ERROR  | load rejected, processor held in reset
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HEADER, DATA, COMMIT, CHECK, DONE, ERROR} stateT;
`else
  typedef enum logic [2:0] {IDLE, HEADER, DATA, COMMIT, DONE, ERROR} stateT;
`endif

  stateT state, nextState;

  logic                xfer;
  logic                startTaken;
  logic                lastByte;
  logic                lastPending;
  logic                byteReadyNext;
  logic [1:0]          byteCnt;
  logic [ADDR_WIDTH:0] wordCount;
  logic [23:0]         shiftReg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          xorAcc;
`endif

  assign xfer = byte_valid && byte_ready;
  assign startTaken = start && (state == IDLE || state == DONE || state == ERROR);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    lastByte  = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) nextState = HEADER;
      end
      HEADER: begin
        if (xfer) begin
          if (byte_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            nextState = CHECK;
`else
            nextState = DONE;
`endif
          end else if (int'(byte_data) > DEPTH) begin
            nextState = ERROR;
          end else begin
            nextState = DATA;
          end
        end
      end
      DATA: begin
        // the final word's strobe cycle stays in DATA with byte_ready already low
        if (lastPending) nextState = COMMIT;
        else if (xfer && byteCnt == 2'd3 && (words_loaded + 1'b1) == wordCount) lastByte = 1'b1;
      end
      COMMIT: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        nextState = CHECK;
`else
        nextState = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) nextState = (byte_data == xorAcc) ? DONE : ERROR;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    byteReadyNext = 1'b0;
    case (nextState)
      HEADER:  byteReadyNext = 1'b1;
      DATA:    byteReadyNext = !lastByte && !lastPending;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:   byteReadyNext = 1'b1;
`endif
      default: byteReadyNext = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_ready   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      lastPending  <= 1'b0;
      byteCnt      <= '0;
      wordCount    <= '0;
      shiftReg     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xorAcc       <= '0;
`endif
    end else begin
      byte_ready  <= byteReadyNext;
      done        <= (nextState == DONE);
      error       <= (nextState == ERROR);
      cpu_reset   <= (nextState != DONE);
      lastPending <= lastByte;
      wr_en       <= 1'b0;

      // address and count advance on the cycle the strobe is visible
      if (wr_en) begin
        words_loaded <= words_loaded + 1'b1;
        if (wr_addr != {ADDR_WIDTH{1'b1}}) wr_addr <= wr_addr + 1'b1;
      end

      if (startTaken) begin
        words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xorAcc       <= '0;
`endif
      end

      if (state == HEADER && nextState == DATA) begin
        wordCount <= (ADDR_WIDTH+1)'(byte_data);
        byteCnt   <= '0;
        wr_addr   <= '0;
      end

      if (state == DATA && xfer) begin
        byteCnt  <= byteCnt + 1'b1;
        shiftReg <= {shiftReg[15:0], byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
        xorAcc   <= xorAcc ^ byte_data;
`endif
        if (byteCnt == 2'd3) begin
          wr_en   <= 1'b1;
          wr_data <= DATA_WIDTH'({shiftReg, byte_data});
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a monitor pops them on each wr_en.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  imem_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  logic [37:0] expQ[$];
  int wrCycles[$];

  always @(posedge clock) cycle <= cycle + 1;

  function automatic void check(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // monitor: every write strobe must match the oldest queued expectation
  always @(negedge clock) begin
    if (!reset && wr_en) begin
      if (expQ.size() == 0) begin
        check("unexpected_write", {26'd0, wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [37:0] e;
        e = expQ.pop_front();
        check("wr_addr", wr_addr, e[37:32]);
        check("wr_data", wr_data, e[31:0]);
        wrCycles.push_back(cycle);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    byte_valid = 1'b0;
    tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (byte_ready) ok = 1'b1;
      tick();
    end
    if (!ok) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic startLoad();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_start", byte_ready, 1);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  logic [7:0] img [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    img[0] = 8'h20; img[1] = 8'h08; img[2] = 8'h00; img[3] = 8'h05;
    img[4] = 8'h8C; img[5] = 8'h09; img[6] = 8'h00; img[7] = 8'h00;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkResetValues("reset");

    // bytes offered in IDLE must be ignored
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (10) tick();
    check("idle_ready", byte_ready, 0);
    check("idle_done", done, 0);
    byte_valid = 1'b0;
    tick();

    // full-rate two-word load
    expQ.push_back({6'd0, 32'h2008_0005});
    expQ.push_back({6'd1, 32'h8C09_0000});
    wrCycles.delete();
    startLoad();
    check("cpu_reset_on_start", cpu_reset, 1);
    sendByte(8'h02);
    for (int i = 0; i < 8; i++) sendByte(img[i]);
    byte_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    tick(); tick();
    check("full_words", words_loaded, 2);
    sendByte(8'hA8);
    byte_valid = 1'b0;
    check("full_done", done, 1);
    check("full_cpu_reset", cpu_reset, 0);
`else
    check("full_done_k", done, 0);
    tick();
    check("full_done_k1", done, 0);
    check("full_words", words_loaded, 2);
    tick();
    check("full_done_k2", done, 1);
    check("full_cpu_reset_k2", cpu_reset, 0);
`endif
    check("full_wr_count", wrCycles.size(), 2);
    if (wrCycles.size() == 2) check("full_wr_spacing", wrCycles[1] - wrCycles[0], 4);

    // same image with byte_valid toggling
    expQ.push_back({6'd0, 32'h2008_0005});
    expQ.push_back({6'd1, 32'h8C09_0000});
    startLoad();
    check("restart_done_cleared", done, 0);
    check("restart_words_cleared", words_loaded, 0);
    sendByte(8'h02);
    idle();
    for (int i = 0; i < 8; i++) begin
      sendByte(img[i]);
      idle();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(8'hA8);
    byte_valid = 1'b0;
`endif
    tick(); tick();
    check("gap_done", done, 1);
    check("gap_words", words_loaded, 2);

    // oversize header rejected, then an empty image succeeds
    startLoad();
    sendByte(8'h41);
    byte_valid = 1'b0;
    tick();
    check("big_error", error, 1);
    check("big_cpu_reset", cpu_reset, 1);
    check("big_done", done, 0);
    check("big_ready", byte_ready, 0);
    startLoad();
    check("empty_error_cleared", error, 0);
    sendByte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(8'h00);
`endif
    byte_valid = 1'b0;
    check("empty_done", done, 1);
    check("empty_words", words_loaded, 0);
    check("empty_error", error, 0);

    // reset in the middle of the second word
    expQ.push_back({6'd0, 32'h2008_0005});
    startLoad();
    sendByte(8'h02);
    for (int i = 0; i < 6; i++) sendByte(img[i]);
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    checkResetValues("midreset");
    reset = 1'b0;
    tick();
    check("midreset_queue", expQ.size(), 0);

    expQ.push_back({6'd0, 32'h2008_0005});
    expQ.push_back({6'd1, 32'h8C09_0000});
    startLoad();
    sendByte(8'h02);
    for (int i = 0; i < 8; i++) sendByte(img[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_valid = 1'b0;
    tick(); tick();
    sendByte(8'hA8);
`endif
    byte_valid = 1'b0;
    tick(); tick();
    check("reload_done", done, 1);
    check("reload_words", words_loaded, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // good and bad checksum on a one-word image
    expQ.push_back({6'd0, 32'h1234_5678});
    startLoad();
    sendByte(8'h01);
    sendByte(8'h12); sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
    byte_valid = 1'b0;
    tick(); tick();
    sendByte(8'h08);
    byte_valid = 1'b0;
    check("cs_good_done", done, 1);
    check("cs_good_error", error, 0);

    expQ.push_back({6'd0, 32'h1234_5678});
    startLoad();
    sendByte(8'h01);
    sendByte(8'h12); sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
    byte_valid = 1'b0;
    tick(); tick();
    sendByte(8'h09);
    byte_valid = 1'b0;
    check("cs_bad_error", error, 1);
    check("cs_bad_cpu_reset", cpu_reset, 1);
    check("cs_bad_done", done, 0);
`endif

    repeat (3) tick();
    check("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
